// File: rtl/exp5_fluxo_dados.sv
// Memory-game datapath: sequence ROM, address counter, play register, comparator, press-edge detector.
// All state updates on the clock edge; outputs are combinational from state and chaves only; no backpressure.
module exp5_fluxo_dados #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              zeraC,
    input  logic              contaC,
    input  logic              zeraR,
    input  logic              registraR,
    input  logic [DATA_W-1:0] chaves,
    output logic              jogada,
    output logic              igual,
    output logic              fim,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [DATA_W-1:0] db_memoria,
    output logic [DATA_W-1:0] db_jogada,
    output logic              db_tem_jogada
);

    logic [ADDR_W-1:0] contagem;
    logic [DATA_W-1:0] jogada_reg;
    logic [DATA_W-1:0] memoria;
    logic              tem_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
        end else if (zeraC) begin
            contagem <= '0;
        end else if (contaC) begin
            contagem <= contagem + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            jogada_reg <= '0;
        end else if (zeraR) begin
            jogada_reg <= '0;
        end else if (registraR) begin
            jogada_reg <= chaves;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tem_d <= 1'b0;
        end else begin
            tem_d <= |chaves;
        end
    end

    // Fixed game sequence, read asynchronously from the counter.
    always_comb begin
        memoria = '0;
        case (contagem)
            4'd0:  memoria = DATA_W'(4'b0001);
            4'd1:  memoria = DATA_W'(4'b0010);
            4'd2:  memoria = DATA_W'(4'b0100);
            4'd3:  memoria = DATA_W'(4'b1000);
            4'd4:  memoria = DATA_W'(4'b0100);
            4'd5:  memoria = DATA_W'(4'b0010);
            4'd6:  memoria = DATA_W'(4'b0001);
            4'd7:  memoria = DATA_W'(4'b0001);
            4'd8:  memoria = DATA_W'(4'b0010);
            4'd9:  memoria = DATA_W'(4'b0010);
            4'd10: memoria = DATA_W'(4'b0100);
            4'd11: memoria = DATA_W'(4'b0100);
            4'd12: memoria = DATA_W'(4'b1000);
            4'd13: memoria = DATA_W'(4'b1000);
            4'd14: memoria = DATA_W'(4'b0001);
            4'd15: memoria = DATA_W'(4'b0100);
            default: memoria = '0;
        endcase
    end

    // A direct change between two pressed patterns keeps |chaves high, so it gives no new pulse.
    assign jogada        = (|chaves) & ~tem_d;
    assign igual         = (jogada_reg == memoria);
    assign fim           = (contagem == {ADDR_W{1'b1}});
    assign db_contagem   = contagem;
    assign db_memoria    = memoria;
    assign db_jogada     = jogada_reg;
    assign db_tem_jogada = tem_d;

endmodule

// File: tb/tb_exp5_fluxo_dados.sv
// Scoreboard bench for the memory-game datapath.
module tb_exp5_fluxo_dados;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       zeraC = 1'b0;
    logic       contaC = 1'b0;
    logic       zeraR = 1'b0;
    logic       registraR = 1'b0;
    logic [3:0] chaves = 4'b0000;
    logic       jogada, igual, fim, db_tem_jogada;
    logic [3:0] db_contagem, db_memoria, db_jogada;

    exp5_fluxo_dados #(.ADDR_W(4), .DATA_W(4)) dut (
        .clock(clock), .reset(reset), .zeraC(zeraC), .contaC(contaC),
        .zeraR(zeraR), .registraR(registraR), .chaves(chaves),
        .jogada(jogada), .igual(igual), .fim(fim),
        .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_jogada(db_jogada), .db_tem_jogada(db_tem_jogada)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] cnt;
        logic [3:0] jog;
        logic [3:0] mem;
        logic       igual;
        logic       fim;
        logic       pulse;
        logic       tem;
    } exp_t;

    exp_t sb[$];

    logic [3:0] rom_tbl [16];
    logic [3:0] m_cnt, m_reg;
    logic       m_tem;
    logic       m_valid = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare settled outputs, then advance the model past the next posedge.
    task automatic cyc(input logic rst, input logic zc, input logic cc,
                       input logic zr, input logic rr, input logic [3:0] ch);
        exp_t e;
        exp_t o;
        @(negedge clock);
        reset = rst; zeraC = zc; contaC = cc; zeraR = zr; registraR = rr; chaves = ch;
        if (m_valid) begin
            e.cnt   = m_cnt;
            e.jog   = m_reg;
            e.mem   = rom_tbl[m_cnt];
            e.igual = (m_reg == rom_tbl[m_cnt]);
            e.fim   = (m_cnt == 4'd15);
            e.pulse = (ch != 4'b0000) && !m_tem;
            e.tem   = m_tem;
            sb.push_back(e);
        end
        #1;
        if (sb.size() > 0) begin
            o = sb.pop_front();
            chk("db_contagem",   32'(db_contagem),   32'(o.cnt));
            chk("db_jogada",     32'(db_jogada),     32'(o.jog));
            chk("db_memoria",    32'(db_memoria),    32'(o.mem));
            chk("igual",         32'(igual),         32'(o.igual));
            chk("fim",           32'(fim),           32'(o.fim));
            chk("jogada",        32'(jogada),        32'(o.pulse));
            chk("db_tem_jogada", 32'(db_tem_jogada), 32'(o.tem));
        end
        if (rst) begin
            m_cnt = 4'd0; m_reg = 4'd0; m_tem = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (zc)      m_cnt = 4'd0;
            else if (cc) m_cnt = m_cnt + 4'd1;
            if (zr)      m_reg = 4'd0;
            else if (rr) m_reg = ch;
            m_tem = (ch != 4'b0000);
        end
    endtask

    task automatic go_to(input int n);
        cyc(0, 1, 0, 0, 0, 4'b0000);
        for (int k = 0; k < n; k++) cyc(0, 0, 1, 0, 0, 4'b0000);
    endtask

    initial begin
        rom_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                    4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};
        m_cnt = 4'd0; m_reg = 4'd0; m_tem = 1'b0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 4'b0000);
        cyc(0, 0, 0, 0, 0, 4'b0000);
        chk("rst_mem", 32'(db_memoria), 32'h1);
        chk("rst_cnt", 32'(db_contagem), 32'h0);
        chk("rst_jogada", 32'(jogada), 32'h0);

        // Edge detector: held press, direct change, release and new press
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 0, 0, 4'b0100);
            chk("hold_pulse", 32'(jogada), (k == 0) ? 32'h1 : 32'h0);
        end
        cyc(0, 0, 0, 0, 0, 4'b0010);
        chk("switch_no_pulse", 32'(jogada), 32'h0);
        cyc(0, 0, 0, 0, 0, 4'b0010);
        cyc(0, 0, 0, 0, 0, 4'b0000);
        cyc(0, 0, 0, 0, 0, 4'b1000);
        chk("repress_pulse", 32'(jogada), 32'h1);
        cyc(0, 0, 0, 0, 0, 4'b1000);
        chk("repress_fall", 32'(jogada), 32'h0);
        cyc(0, 0, 0, 0, 0, 4'b0000);

        // Full correct sequence of 16 rounds
        cyc(0, 1, 0, 1, 0, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 0, 1, rom_tbl[i]);
            cyc(0, 0, 0, 0, 0, rom_tbl[i]);
            chk("seq_igual", 32'(igual), 32'h1);
            chk("seq_fim", 32'(fim), (i == 15) ? 32'h1 : 32'h0);
            cyc(0, 0, 1, 0, 0, 4'b0000);
        end
        cyc(0, 0, 0, 0, 0, 4'b0000);
        chk("wrap_cnt", 32'(db_contagem), 32'h0);

        // Mismatch at address 3
        go_to(3);
        cyc(0, 0, 0, 0, 1, 4'b0100);
        cyc(0, 0, 0, 0, 0, 4'b0000);
        chk("mis_igual", 32'(igual), 32'h0);
        chk("mis_mem", 32'(db_memoria), 32'h8);

        // Clear has priority over count / load
        go_to(7);
        cyc(0, 1, 1, 0, 0, 4'b0000);
        cyc(0, 0, 0, 1, 1, 4'b0001);
        cyc(0, 0, 0, 0, 0, 4'b0000);
        chk("prio_cnt", 32'(db_contagem), 32'h0);
        chk("prio_reg", 32'(db_jogada), 32'h0);

        // Reset mid-operation overrides strobes
        go_to(9);
        cyc(0, 0, 0, 0, 1, 4'b0010);
        cyc(0, 0, 0, 0, 0, 4'b0000);
        chk("pre_rst_reg", 32'(db_jogada), 32'h2);
        cyc(1, 0, 1, 0, 1, 4'b0010);
        cyc(0, 0, 0, 0, 0, 4'b0000);
        chk("mid_rst_cnt", 32'(db_contagem), 32'h0);
        chk("mid_rst_reg", 32'(db_jogada), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
